// File: rtl/inv_mixcolumns_seq.sv
// -----------------------------------------------------------------------------
// inv_mixcolumns_seq
//
// Column-serial AES InvMixColumns engine for the decryption datapath. One
// 128-bit state is accepted over a valid/ready handshake. COLS_PER_CYCLE
// columns are then transformed in place each clock, and the result is
// presented under valid/ready. In bypass mode the state is passed through
// unchanged, for the last decryption round where InvMixColumns is skipped.
//
// Byte layout: byte k = state[8k+7:8k]; column c = bytes 4c..4c+3;
//              row r of column c = byte 4c+r.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   istate / in_bypass are valid
//   in_ready   engine can accept a state (high only in IDLE)
//   istate     input state (128 bits)
//   in_bypass  pass the state unchanged; sampled together with istate
//   out_valid  ostate is valid (high only in DONE)
//   out_ready  consumer accepts ostate
//   ostate     result (128 bits, registered)
//   busy       high while columns are being transformed
// -----------------------------------------------------------------------------
module inv_mixcolumns_seq #(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] istate,
  input  logic         in_bypass,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] ostate,
  output logic         busy
);

  // Only divisors of the column count keep the column counter aligned.
  if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
    $error("inv_mixcolumns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // First column of the final BUSY cycle. With four columns per cycle the
  // step wraps to 0 in two bits, which is harmless: the counter is only ever
  // 0 in that configuration.
  localparam logic [1:0] LAST_COL = 2'(4 - COLS_PER_CYCLE);
  localparam logic [1:0] COL_STEP = 2'(COLS_PER_CYCLE);

  logic [1:0]   r_state;
  logic [127:0] r_data;
  logic [1:0]   r_col;
  logic         r_bypass;

  logic [1:0]   w_col_idx [COLS_PER_CYCLE];
  logic [31:0]  w_col_in  [COLS_PER_CYCLE];
  logic [31:0]  w_col_out [COLS_PER_CYCLE];
  logic [127:0] w_data_upd;

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // InvMixColumns of one column. The 09/0b/0d/0e multiples are built from
  // the x2/x4/x8 chain:
  //   09 = 8+1, 0b = 8+2+1, 0d = 8+4+1, 0e = 8+4+2
  function automatic logic [31:0] inv_col(input logic [31:0] col);
    logic [7:0] a   [4];
    logic [7:0] m9  [4];
    logic [7:0] mb  [4];
    logic [7:0] md  [4];
    logic [7:0] me  [4];
    logic [7:0] x2;
    logic [7:0] x4;
    logic [7:0] x8;
    logic [31:0] res;
    for (int r = 0; r < 4; r++) begin
      a[r]  = col[8*r +: 8];
      x2    = xtime(a[r]);
      x4    = xtime(x2);
      x8    = xtime(x4);
      m9[r] = x8 ^ a[r];
      mb[r] = x8 ^ x2 ^ a[r];
      md[r] = x8 ^ x4 ^ a[r];
      me[r] = x8 ^ x4 ^ x2;
    end
    for (int r = 0; r < 4; r++) begin
      res[8*r +: 8] = me[r] ^ mb[(r + 1) % 4] ^ md[(r + 2) % 4] ^ m9[(r + 3) % 4];
    end
    return res;
  endfunction

  // One InvMixColumns unit per column handled in a cycle; each unit is
  // steered to its column by the running counter.
  for (genvar gi = 0; gi < COLS_PER_CYCLE; gi++) begin : g_col
    assign w_col_idx[gi] = r_col + 2'(gi);
    assign w_col_in[gi]  = r_data[{w_col_idx[gi], 5'd0} +: 32];
    assign w_col_out[gi] = inv_col(w_col_in[gi]);
  end

  always_comb begin
    w_data_upd = r_data;
    for (int k = 0; k < COLS_PER_CYCLE; k++) begin
      w_data_upd[{w_col_idx[k], 5'd0} +: 32] = w_col_out[k];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_data   <= '0;
      r_col    <= '0;
      r_bypass <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_data   <= istate;
            r_bypass <= in_bypass;
            r_col    <= '0;
            r_state  <= in_bypass ? S_DONE : S_BUSY;
          end
        end
        S_BUSY: begin
          // A bypassed state never reaches BUSY; the guard keeps the data
          // untouched should the FSM ever be driven here with the flag set.
          if (!r_bypass) begin
            r_data <= w_data_upd;
          end
          if (r_col == LAST_COL) begin
            r_col   <= '0;
            r_state <= S_DONE;
          end else begin
            r_col <= r_col + COL_STEP;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // All outputs are decoded from registers only.
  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign busy      = (r_state == S_BUSY);
  assign ostate    = r_data;

endmodule

// File: tb/tb_inv_mixcolumns_seq.sv
module tb_inv_mixcolumns_seq;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] istate;
  logic         in_bypass;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] ostate;
  logic         busy;

  logic         in_valid_sw;
  logic         in_ready2, out_valid2, busy2;
  logic [127:0] ostate2;
  logic         in_ready4, out_valid4, busy4;
  logic [127:0] ostate4;

  always #5 clk = ~clk;

  inv_mixcolumns_seq u_dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .istate(istate), .in_bypass(in_bypass),
    .out_valid(out_valid), .out_ready(out_ready),
    .ostate(ostate), .busy(busy)
  );

  inv_mixcolumns_seq #(.COLS_PER_CYCLE(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid_sw), .in_ready(in_ready2),
    .istate(istate), .in_bypass(in_bypass),
    .out_valid(out_valid2), .out_ready(out_ready),
    .ostate(ostate2), .busy(busy2)
  );

  inv_mixcolumns_seq #(.COLS_PER_CYCLE(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid_sw), .in_ready(in_ready4),
    .istate(istate), .in_bypass(in_bypass),
    .out_valid(out_valid4), .out_ready(out_ready),
    .ostate(ostate4), .busy(busy4)
  );

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [127:0] KA_IN   = 128'hc6c6c6c6_01010101_9d58dc9f_bca14d8e;
  localparam logic [127:0] KA_OUT  = 128'hc6c6c6c6_01010101_5c220af2_455313db;
  localparam logic [127:0] BY_IN   = 128'h00112233_44556677_8899aabb_ccddeeff;
  localparam logic [127:0] FIPS_IN = 128'h4c260628_7ad3f848_9a19cbe0_e5816604;
  localparam logic [127:0] FIPS_OUT= 128'he598271e_f11141b8_ae52b4e0_305dbfd4;

  typedef struct {
    logic [127:0] st;
    logic         byp;
    logic [127:0] exp;
    int           lat;
    int           bcnt;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Forward MixColumns reference, used to build round-trip stimulus.
  function automatic logic [127:0] fwd_mix(input logic [127:0] s);
    logic [127:0] r;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[32*c +: 8];
      a1 = s[32*c + 8 +: 8];
      a2 = s[32*c + 16 +: 8];
      a3 = s[32*c + 24 +: 8];
      r[32*c +: 8]      = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
      r[32*c + 8 +: 8]  = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
      r[32*c + 16 +: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
      r[32*c + 24 +: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
    end
    return r;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Called at #1 after a rising edge with the main DUT idle. Returns the
  // result, the number of samples up to and including the first one with
  // out_valid high (acceptance edge counts as 1), and busy cycles seen.
  task automatic run_one(input logic [127:0] st, input logic byp,
                         output logic [127:0] got, output int lat, output int bcnt);
    istate    = st;
    in_bypass = byp;
    in_valid  = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat  = 1;
    bcnt = 0;
    while (!out_valid && lat < 20) begin
      bcnt += int'(busy);
      @(posedge clk); #1;
      lat++;
    end
    got = ostate;
  endtask

  logic [127:0] got, got2, got4;
  int lat, bcnt, lat2, lat4;

  logic [127:0] q [$];
  int n_in, n_out, cyc;
  logic fire_in, fire_out;
  logic [127:0] pend_orig, pend_feed;
  logic pend_byp;

  initial begin
    vecs[0] = '{KA_IN,    1'b0, KA_OUT,   5, 4};
    vecs[1] = '{BY_IN,    1'b1, BY_IN,    1, 0};
    vecs[2] = '{128'h0,   1'b0, 128'h0,   5, 4};
    vecs[3] = '{{128{1'b1}}, 1'b0, {128{1'b1}}, 5, 4};
    vecs[4] = '{FIPS_IN,  1'b0, FIPS_OUT, 5, 4};
    vecs[5] = '{FIPS_IN,  1'b1, FIPS_IN,  1, 0};

    rst_n = 1'b0; in_valid = 1'b0; in_valid_sw = 1'b0;
    out_ready = 1'b1; istate = '0; in_bypass = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_in_ready",  128'(in_ready),  128'd1);
    check("reset_out_valid", 128'(out_valid), 128'd0);
    check("reset_busy",      128'(busy),      128'd0);
    check("reset_ostate",    ostate,          128'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Table-driven vectors with out_ready held high.
    for (int i = 0; i < 6; i++) begin
      run_one(vecs[i].st, vecs[i].byp, got, lat, bcnt);
      check($sformatf("vec%0d_ostate", i), got, vecs[i].exp);
      check($sformatf("vec%0d_latency", i), 128'(lat), 128'(vecs[i].lat));
      check($sformatf("vec%0d_busy_cycles", i), 128'(bcnt), 128'(vecs[i].bcnt));
      @(posedge clk); #1;
      check($sformatf("vec%0d_back_to_idle", i), 128'({in_ready, out_valid}), 128'(2'b10));
    end

    // Reset asserted in the middle of BUSY.
    istate = FIPS_IN; in_bypass = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("midbusy_busy_before_reset", 128'(busy), 128'd1);
    rst_n = 1'b0;
    #1;
    check("async_reset_busy", 128'(busy), 128'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("midreset_out_valid", 128'(out_valid), 128'd0);
    check("midreset_in_ready",  128'(in_ready),  128'd1);
    check("midreset_ostate",    ostate,          128'd0);
    check("midreset_busy",      128'(busy),      128'd0);
    lat = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      lat += int'(out_valid);
    end
    check("aborted_never_output", 128'(lat), 128'd0);
    run_one(KA_IN, 1'b0, got, lat, bcnt);
    check("after_reset_ostate",  got, KA_OUT);
    check("after_reset_latency", 128'(lat), 128'd5);
    @(posedge clk); #1;

    // Backpressure: out_ready low for 10 clocks, in_valid pulses and bypass
    // toggling must be ignored.
    out_ready = 1'b0;
    run_one(FIPS_IN, 1'b0, got, lat, bcnt);
    check("bp_ostate", got, FIPS_OUT);
    for (int c = 0; c < 10; c++) begin
      in_valid  = (c % 2 == 0);
      istate    = rand128();
      in_bypass = ~in_bypass;
      @(posedge clk); #1;
      check($sformatf("bp_hold%0d", c), ostate, FIPS_OUT);
      check($sformatf("bp_flags%0d", c), 128'({out_valid, in_ready, busy}), 128'(3'b100));
    end
    in_valid  = 1'b0;
    in_bypass = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_idle", 128'({in_ready, out_valid}), 128'(2'b10));
    @(posedge clk); #1;
    check("bp_nothing_accepted", 128'({busy, out_valid, in_ready}), 128'(3'b001));

    // Parameter sweep: two and four columns per clock.
    istate = KA_IN; in_bypass = 1'b0; in_valid_sw = 1'b1;
    @(posedge clk); #1;
    in_valid_sw = 1'b0;
    lat2 = 0; lat4 = 0; got2 = '0; got4 = '0;
    for (int c = 1; c <= 10; c++) begin
      if (out_valid2 && lat2 == 0) begin lat2 = c; got2 = ostate2; end
      if (out_valid4 && lat4 == 0) begin lat4 = c; got4 = ostate4; end
      @(posedge clk); #1;
    end
    check("cpc2_ostate",  got2, KA_OUT);
    check("cpc2_latency", 128'(lat2), 128'd3);
    check("cpc4_ostate",  got4, KA_OUT);
    check("cpc4_latency", 128'(lat4), 128'd2);

    // Round-trip with random throttling and occasional bypass.
    n_in = 0; n_out = 0; cyc = 0;
    pend_orig = rand128();
    pend_byp  = ($urandom_range(0, 7) == 0);
    pend_feed = pend_byp ? pend_orig : fwd_mix(pend_orig);
    in_valid = 1'b0; out_ready = 1'b0;
    while (n_out < 1000 && cyc < 60000) begin
      @(negedge clk);
      fire_in  = in_valid && in_ready;
      fire_out = out_valid && out_ready;
      if (fire_out) begin
        if (q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL roundtrip_spurious: got output %h with nothing pending", ostate);
        end else begin
          check($sformatf("roundtrip%0d", n_out), ostate, q.pop_front());
        end
        n_out++;
      end
      if (fire_in) begin
        q.push_back(pend_orig);
        n_in++;
      end
      @(posedge clk); #1;
      cyc++;
      if (fire_in) begin
        pend_orig = rand128();
        pend_byp  = ($urandom_range(0, 7) == 0);
        pend_feed = pend_byp ? pend_orig : fwd_mix(pend_orig);
      end
      in_valid  = (n_in < 1000) && ($urandom_range(0, 3) != 0);
      istate    = pend_feed;
      in_bypass = pend_byp;
      out_ready = ($urandom_range(0, 3) != 0);
    end
    check("roundtrip_accepted", 128'(n_in),  128'd1000);
    check("roundtrip_outputs",  128'(n_out), 128'd1000);
    in_valid = 1'b0; out_ready = 1'b1;
    lat = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      lat += int'(out_valid);
    end
    check("roundtrip_no_extra_output", 128'(lat), 128'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
